// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the fetch stage and the decoders.
//   XLEN / ILEN      : datapath and instruction widths
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown while no instruction is held
//   OPC_*            : major opcode constants used by the decoders
//   fetch_state_t    : fetch FSM encoding; StFault exists only with MISALIGN_TRAP_EN
// Configuration macro: MISALIGN_TRAP_EN
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StValid
`ifdef MISALIGN_TRAP_EN
        ,
        StFault
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection (reset / pc+4 / redirect target).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pc <= RESET_PC)
//   pc_inc       advance pc by 4 (wraps modulo 2^64)
//   pc_load      load redirect_pc (takes priority over pc_inc)
//   redirect_pc  redirect target
//   pc           current fetch PC
// Configuration macro: MISALIGN_TRAP_EN. Without it the target's low two bits are
// cleared here; with it the FSM never loads a misaligned target.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_inc,
    input  logic            pc_load,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;

`ifdef MISALIGN_TRAP_EN
    assign target = redirect_pc;
`else
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = target;
        end else if (pc_inc) begin
            pc_d = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV64 fetch stage: fetches 32-bit words over a req/ack memory handshake and hands one
// instruction plus its PC to decode over valid/ready. Accepts downstream redirects.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req/imem_addr          fetch request, held with stable address until imem_ack
//   imem_ack/imem_rdata         response strobe and instruction word
//   if_valid/if_ready           decode handshake
//   if_instruction/if_pc        instruction and its address
//   redirect/redirect_pc        replace the fetch PC
//   fetch_fault                 sticky misaligned-redirect flag (0 without the macro)
// Configuration macro: MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc;
    logic [63:0]  drain_addr_q;
    logic [31:0]  if_instruction_q;
    logic [63:0]  if_pc_q;
    logic         pc_inc, pc_load, capture;
    logic         misalign, take;

`ifdef MISALIGN_TRAP_EN
    logic fault_pend_q, fault_pend_d;
    assign misalign = redirect & (|redirect_pc[1:0]);
`else
    assign misalign = 1'b0;
`endif
    assign take = redirect & ~misalign;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            drain_addr_q     <= RESET_PC;
            if_instruction_q <= NOP_INSTR;
            if_pc_q          <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_pend_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // Remember the in-flight address so a redirect can't move it mid-request.
            if (state_q == StFetch) begin
                drain_addr_q <= pc;
            end
            if (capture) begin
                if_instruction_q <= imem_rdata;
                if_pc_q          <= pc;
            end
`ifdef MISALIGN_TRAP_EN
            fault_pend_q <= fault_pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        capture = 1'b0;
`ifdef MISALIGN_TRAP_EN
        fault_pend_d = fault_pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                pc_load = take;
                state_d = StFetch;
`ifdef MISALIGN_TRAP_EN
                if (misalign) state_d = StFault;
`endif
            end
            StFetch: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_load = take;
                        state_d = StFetch;
`ifdef MISALIGN_TRAP_EN
                        if (misalign) state_d = StFault;
`endif
                    end else begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = StValid;
                    end
                end else if (redirect) begin
                    pc_load = take;
                    state_d = StDrain;
`ifdef MISALIGN_TRAP_EN
                    fault_pend_d = misalign;
`endif
                end
            end
            StDrain: begin
                pc_load = take;
                if (imem_ack) begin
                    state_d = StFetch;
`ifdef MISALIGN_TRAP_EN
                    fault_pend_d = 1'b0;
                    if (fault_pend_q || misalign) state_d = StFault;
`endif
                end
`ifdef MISALIGN_TRAP_EN
                else if (misalign) begin
                    fault_pend_d = 1'b1;
                end
`endif
            end
            StValid: begin
                // Redirect kills the held instruction even if decode accepts it.
                if (redirect) begin
                    pc_load = take;
                    state_d = StFetch;
`ifdef MISALIGN_TRAP_EN
                    if (misalign) state_d = StFault;
`endif
                end else if (if_ready) begin
                    state_d = StFetch;
                end
            end
`ifdef MISALIGN_TRAP_EN
            StFault: state_d = StFault;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req       = (state_q == StFetch) || (state_q == StDrain);
        imem_addr      = (state_q == StDrain) ? drain_addr_q : pc;
        if_valid       = (state_q == StValid);
        if_instruction = if_instruction_q;
        if_pc          = if_pc_q;
`ifdef MISALIGN_TRAP_EN
        fetch_fault    = (state_q == StFault);
`else
        fetch_fault    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    // Second instance at the top of the address space, zero-wait memory.
    logic        imem_req2, if_valid2, fetch_fault2;
    logic [63:0] imem_addr2, if_pc2;
    logic [31:0] if_instruction2;

    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    instruction_fetch_unit #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
    ) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_ack       (imem_req2),
        .imem_rdata     (32'h0000_0013),
        .if_valid       (if_valid2),
        .if_ready       (1'b1),
        .if_instruction (if_instruction2),
        .if_pc          (if_pc2),
        .redirect       (1'b0),
        .redirect_pc    (64'h0),
        .fetch_fault    (fetch_fault2)
    );

    localparam int MIdle = 0, MFetch = 1, MDrain = 2, MValid = 3, MFault = 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] seen_pc[$];
    int          errors = 0;
    int          checks = 0;
    int          mst;
    int          lat;
    int          wait_cnt;
    logic [63:0] epc, edrain;
    bit          epend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: check current outputs against the model, drive inputs, advance.
    task automatic cycle(input logic rdy, input logic redir, input logic [63:0] rpc);
        logic        ack, req_prev, bad;
        logic [63:0] tgt;
        check_eq("imem_req", imem_req, (mst == MFetch || mst == MDrain));
        if (mst == MFetch) check_eq("imem_addr", imem_addr, epc);
        if (mst == MDrain) check_eq("drain_addr", imem_addr, edrain);
        check_eq("if_valid", if_valid, mst == MValid);
        check_eq("fetch_fault", fetch_fault, mst == MFault);
        if (mst == MValid) begin
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got valid output expected none");
            end else begin
                check_eq("if_instruction", if_instruction, sbq[0].ins);
                check_eq("if_pc", if_pc, sbq[0].pc);
            end
        end
        req_prev    = imem_req;
        ack         = imem_req && (wait_cnt >= lat);
        imem_ack    = ack;
        imem_rdata  = ack ? mem_word(imem_addr) : $urandom;
        if_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
`ifdef MISALIGN_TRAP_EN
        bad = redir && (rpc[1:0] != 2'b00);
        tgt = rpc;
`else
        bad = 1'b0;
        tgt = {rpc[63:2], 2'b00};
`endif
        case (mst)
            MIdle: begin
                if (redir) epc = tgt;
                mst = bad ? MFault : MFetch;
            end
            MFetch: begin
                if (ack && !redir) begin
                    sbq.push_back('{pc: epc, ins: mem_word(epc)});
                    epc = epc + 64'd4;
                    mst = MValid;
                end else if (ack) begin
                    if (bad) mst = MFault;
                    else epc = tgt;
                end else if (redir) begin
                    edrain = epc;
                    if (bad) epend = 1'b1;
                    else epc = tgt;
                    mst = MDrain;
                end
            end
            MDrain: begin
                if (bad) epend = 1'b1;
                else if (redir) epc = tgt;
                if (ack) begin
                    mst   = epend ? MFault : MFetch;
                    epend = 1'b0;
                end
            end
            MValid: begin
                if (redir || rdy) begin
                    if (sbq.size() != 0) begin
                        if (!redir) seen_pc.push_back(sbq[0].pc);
                        void'(sbq.pop_front());
                    end
                    if (redir && !bad) epc = tgt;
                    mst = bad ? MFault : MFetch;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        wait_cnt = (req_prev && !ack) ? wait_cnt + 1 : 0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mst         = MIdle;
        epc         = 64'h0;
        epend       = 1'b0;
        wait_cnt    = 0;
        sbq.delete();
        seen_pc.delete();
        @(posedge clk);
        #1;
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_imem_addr", imem_addr, 64'h0);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_instruction", if_instruction, 32'h0000_0013);
        check_eq("rst_if_pc", if_pc, 64'h0);
        check_eq("rst_fetch_fault", fetch_fault, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] wrap_addr[$];

        do_reset();

        // Zero-wait memory, decode always ready.
        lat = 0;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 64'h0);
        check_eq("seq_count_ge3", seen_pc.size() >= 3, 1'b1);
        if (seen_pc.size() >= 3) begin
            check_eq("seq_pc0", seen_pc[0], 64'h0);
            check_eq("seq_pc1", seen_pc[1], 64'h4);
            check_eq("seq_pc2", seen_pc[2], 64'h8);
        end

        // Three wait states per access.
        lat = 3;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 64'h0);

        // Redirect while a request is outstanding.
        for (int i = 0; i < 20 && !(mst == MFetch && wait_cnt == 1); i++)
            cycle(1'b1, 1'b0, 64'h0);
        check_eq("redir_setup_req", imem_req, 1'b1);
        cycle(1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 10 && mst != MFetch; i++) cycle(1'b1, 1'b0, 64'h0);
        check_eq("redir_addr", imem_addr, 64'h100);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 64'h0);

        // Decode stalls for 5 cycles, then a redirect kills the held instruction.
        lat = 0;
        for (int i = 0; i < 10 && mst != MValid; i++) cycle(1'b0, 1'b0, 64'h0);
        check_eq("stall_valid", if_valid, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 64'h40);
        check_eq("kill_valid", if_valid, 1'b0);
        check_eq("kill_next_addr", imem_addr, 64'h40);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0);

        // Misaligned redirect.
        for (int i = 0; i < 10 && mst != MValid; i++) cycle(1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 64'h102);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0);
        check_eq("trap_fault", fetch_fault, 1'b1);
        check_eq("trap_no_req", imem_req, 1'b0);
`else
        check_eq("align_req", imem_req, 1'b1);
        check_eq("align_addr", imem_addr, 64'h100);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0);
`endif

        // Reset in the middle of a request drops it immediately.
        do_reset();
        lat = 3;
        cycle(1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 64'h0);
        check_eq("mid_req_before", imem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_req_dropped", imem_req, 1'b0);
        check_eq("mid_fault_clear", fetch_fault, 1'b0);

        // PC wrap on the second instance.
        do_reset();
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req2) wrap_addr.push_back(imem_addr2);
            cycle(1'b1, 1'b0, 64'h0);
        end
        check_eq("wrap_count_ge2", wrap_addr.size() >= 2, 1'b1);
        if (wrap_addr.size() >= 2) begin
            check_eq("wrap_first", wrap_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check_eq("wrap_second", wrap_addr[1], 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
